// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Shares one UART TX fifo between NREQ requesters (round-robin push side)
// and drains it into the UART serializer through a START/BUSY handshake.
// Also owns flush sequencing and the completed-byte counter.
module uart_tx_sched #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BUSY_TMO   = 15,
  parameter int CNT_W      = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       ENABLE,
  input  logic [NREQ-1:0]            REQ_VALID,
  input  logic [NREQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NREQ-1:0]            REQ_READY,
  input  logic                       FLUSH_REQ,
  output logic [DATA_WIDTH-1:0]      FIFO_DATA_IN,
  output logic                       FIFO_PUSH,
  output logic                       FIFO_POP,
  output logic                       FIFO_FLUSH,
  input  logic [DATA_WIDTH-1:0]      FIFO_DATA_OUT,
  input  logic                       FIFO_FULL,
  input  logic                       FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0]      TX_DATA,
  output logic                       TX_START,
  input  logic                       TX_BUSY,
  output logic                       TX_ERR,
  output logic [CNT_W-1:0]           TX_COUNT,
  output logic                       IDLE
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int TMR_W = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [PTR_W-1:0]        r_ptr;
  logic [TMR_W-1:0]        r_timer;
  logic [CNT_W-1:0]        r_count;
  logic [DATA_WIDTH-1:0]   r_tx_data;

  logic                    w_en;
  logic                    w_found;
  logic [PTR_W-1:0]        w_scan_idx;
  logic [PTR_W-1:0]        w_gnt_idx;
  logic                    w_grant;
  logic                    w_pop;
  logic                    w_tx_start;
  logic                    w_tx_err;
  logic                    w_done;

  // Everything except TX_COUNT behaves as if in reset while RESET or !ENABLE.
  assign w_en = ENABLE && !RESET;

  // Round-robin search: start at r_ptr, wrap explicitly at NREQ-1.
  always_comb begin
    w_found    = 1'b0;
    w_gnt_idx  = '0;
    w_scan_idx = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && REQ_VALID[w_scan_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan_idx;
      end
      w_scan_idx = (w_scan_idx == PTR_W'(NREQ - 1)) ? '0 : w_scan_idx + 1'b1;
    end
  end

  // A full fifo still takes a push in the same cycle it is popped; flush wins.
  assign w_grant = w_en && !FLUSH_REQ && w_found && (!FIFO_FULL || w_pop);

  // Decode the winning index into the one-hot accept and the fifo write byte.
  always_comb begin
    REQ_READY    = '0;
    FIFO_DATA_IN = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant && (w_gnt_idx == PTR_W'(i))) begin
        REQ_READY[i] = 1'b1;
        FIFO_DATA_IN = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer moves past the winner; untouched by flush or an idle cycle.
  always_ff @(posedge CLK) begin
    if (!w_en) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_gnt_idx == PTR_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Pop-side state register.
  always_ff @(posedge CLK) begin
    if (!w_en) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Pop-side next state and handshake strobes.
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_tx_start = 1'b0;
    w_tx_err   = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Never pop an empty fifo: it would still advance its read pointer.
        if (w_en && !FLUSH_REQ && !FIFO_EMPTY) begin
          w_pop  = 1'b1;
          w_next = S_START;
        end
      end
      S_START: begin
        w_tx_start = w_en;
        w_next     = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (TX_BUSY) begin
          w_next = S_WAIT_DONE;
        end else if (r_timer == TMR_W'(BUSY_TMO - 1)) begin
          // Serializer never acknowledged: drop the byte uncounted.
          w_tx_err = w_en;
          w_next   = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!TX_BUSY) begin
          w_done = w_en;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // BUSY wait timer: cleared in S_START, counts idle cycles in S_WAIT_BUSY.
  always_ff @(posedge CLK) begin
    if (!w_en || (r_state == S_START)) begin
      r_timer <= '0;
    end else if ((r_state == S_WAIT_BUSY) && !TX_BUSY) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Byte handed to the serializer; captured from the fifo head on pop.
  always_ff @(posedge CLK) begin
    if (!w_en) begin
      r_tx_data <= '0;
    end else if (w_pop) begin
      r_tx_data <= FIFO_DATA_OUT;
    end
  end

  // Completed-byte counter: cleared by reset only, held while disabled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (w_done) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign FIFO_PUSH  = w_grant;
  assign FIFO_POP   = w_pop;
  assign FIFO_FLUSH = w_en && FLUSH_REQ;
  assign TX_DATA    = r_tx_data;
  assign TX_START   = w_tx_start;
  assign TX_ERR     = w_tx_err;
  assign TX_COUNT   = r_count;
  assign IDLE       = !w_en || ((r_state == S_IDLE) && FIFO_EMPTY);

endmodule
